// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_WR-1:0]        i_we,
  input  logic [NUM_WR*AW-1:0]     i_waddr,
  input  logic [NUM_WR*XLEN-1:0]   i_wdata,
  input  logic                     i_rsv_valid,
  input  logic [AW-1:0]            i_rsv_addr,
  input  logic [NUM_RD*AW-1:0]     i_raddr,
  output logic [NUM_RD*XLEN-1:0]   o_rdata,
  output logic [NUM_RD-1:0]        o_rbusy,
  output logic [NUM_REGS-1:0]      o_busy_vec
);

  // Register 0 has no storage; it only appears as a constant in the read view.
  logic [XLEN-1:0]     mem_q   [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy_q;
  logic [XLEN-1:0]     rf_view [NUM_REGS];

  logic [NUM_REGS-1:0] wr_hit;
  logic [XLEN-1:0]     wr_val  [NUM_REGS];

  // Per-register write decode; scanning ports in ascending order lets the
  // highest-index enabled port override lower ones.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) wr_val[r] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_we[k] && (i_waddr[k*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = i_wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the storage array is reset explicitly because a reset must leave
  // every register reading as zero, so it maps to resettable flops, not RAM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) mem_q[r] <= wr_val[r];
        // A new reservation outranks a same-cycle writeback of the old producer.
        if (i_rsv_valid && (i_rsv_addr == AW'(r))) busy_q[r] <= 1'b1;
        else if (wr_hit[r])                        busy_q[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) rf_view[r] = mem_q[r];
  end

  assign o_busy_vec = {busy_q, 1'b0};

  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      o_rdata[j*XLEN +: XLEN] = rf_view[i_raddr[j*AW +: AW]];
      o_rbusy[j]              = o_busy_vec[i_raddr[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      // wr_hit[0] is never set, so address 0 still reads as zero and not busy.
      if (wr_hit[i_raddr[j*AW +: AW]]) begin
        o_rdata[j*XLEN +: XLEN] = wr_val[i_raddr[j*AW +: AW]];
        if (!(i_rsv_valid && (i_rsv_addr == i_raddr[j*AW +: AW])))
          o_rbusy[j] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (4 read, 2 write ports, 16 regs).
// Expectations for the same-cycle read follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 4;

  logic                 i_clk;
  logic                 i_rst_n;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic [NREG-1:0]      busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .i_rsv_valid (rsv_valid),
    .i_rsv_addr  (rsv_addr),
    .i_raddr     (raddr),
    .o_rdata     (rdata),
    .o_rbusy     (rbusy),
    .o_busy_vec  (busy_vec)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_valid = 1'b1;
    rsv_addr  = a;
  endtask

  task automatic rsel(input int j, input logic [AW-1:0] a);
    raddr[j*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rd(input int j);
    return rdata[j*XLEN +: XLEN];
  endfunction

  // Clock edge, then clear stimulus and let the read path settle.
  task automatic step();
    @(posedge i_clk);
    #1;
    idle();
    #1;
  endtask

  logic [AW-1:0] sel [3][NRD];

  initial begin
    idle();
    raddr   = '0;
    i_rst_n = 1'b0;
    #2;
    check("reset_busy_vec", 32'(busy_vec), 32'h0);
    check("reset_rdata0", rd(0), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Asynchronous reset mid-cycle wipes data and busy bits.
    @(negedge i_clk);
    wr(0, 4'd5, 32'hDEAD_BEEF);
    rsv(4'd4);
    step();
    for (int j = 0; j < NRD; j++) rsel(j, 4'd5);
    #1;
    check("pre_reset_x5", rd(0), 32'hDEAD_BEEF);
    check("pre_reset_busy", 32'(busy_vec), 32'h0010);
    #1;
    i_rst_n = 1'b0;
    #1;
    for (int j = 0; j < NRD; j++) check($sformatf("async_reset_rd%0d", j), rd(j), 32'h0);
    check("async_reset_busy", 32'(busy_vec), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // x0: writes and reservations are discarded.
    wr(0, 4'd0, 32'h1234_5678);
    rsv(4'd0);
    step();
    rsel(0, 4'd0);
    #1;
    check("x0_read", rd(0), 32'h0);
    check("x0_rbusy", 32'(rbusy[0]), 32'h0);
    check("x0_busy_vec", 32'(busy_vec), 32'h0);

    // Write priority: highest-index enabled port wins; a disabled port never wins.
    wr(0, 4'd7, 32'h1);
    wr(1, 4'd7, 32'h2);
    step();
    wr(0, 4'd8, 32'h11);
    waddr[AW +: AW] = 4'd8;
    wdata[XLEN +: XLEN] = 32'h22;
    step();
    rsel(0, 4'd7);
    rsel(1, 4'd8);
    #1;
    check("prio_x7", rd(0), 32'h2);
    check("prio_x8_p1_off", rd(1), 32'h11);

    // Scoreboard set, clear, reserve-beats-writeback.
    rsv(4'd3);
    step();
    rsel(0, 4'd3);
    #1;
    check("sb_rsv_vec", 32'(busy_vec), 32'h0008);
    check("sb_rsv_rbusy", 32'(rbusy[0]), 32'h1);
    wr(0, 4'd3, 32'hA5);
    step();
    check("sb_clear_vec", 32'(busy_vec), 32'h0);
    check("sb_clear_data", rd(0), 32'hA5);
    wr(1, 4'd3, 32'h5A);
    rsv(4'd3);
    step();
    check("sb_rsv_wins_vec", 32'(busy_vec), 32'h0008);
    check("sb_rsv_wins_data", rd(0), 32'h5A);
    rsv(4'd3);
    wr(0, 4'd6, 32'h66);
    step();
    rsel(1, 4'd6);
    #1;
    check("sb_rereserve_vec", 32'(busy_vec), 32'h0008);
    check("sb_nonbusy_write", rd(1), 32'h66);
    wr(1, 4'd3, 32'h77);
    rsv(4'd2);
    step();
    check("sb_mixed_vec", 32'(busy_vec), 32'h0004);
    check("sb_mixed_data", rd(0), 32'h77);

    // Same-cycle read of a register being written.
    wr(0, 4'd9, 32'h1111);
    rsv(4'd9);
    step();
    wr(1, 4'd9, 32'hCAFE);
    rsel(2, 4'd9);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_cycle", rd(2), 32'hCAFE);
    check("byp_rbusy", 32'(rbusy[2]), 32'h0);
`else
    check("nobyp_same_cycle", rd(2), 32'h1111);
    check("nobyp_rbusy", 32'(rbusy[2]), 32'h1);
`endif
    step();
    check("byp_next_cycle", rd(2), 32'hCAFE);
    check("byp_next_rbusy", 32'(rbusy[2]), 32'h0);

    // Port scaling: x1..x15 = i*3, two writes per cycle.
    for (int i = 1; i < NREG; i += 2) begin
      wr(0, AW'(i), 32'(i * 3));
      if (i + 1 < NREG) wr(1, AW'(i + 1), 32'((i + 1) * 3));
      step();
    end
    check("scale_busy_clear", 32'(busy_vec), 32'h0);
    rsv(4'd12);
    step();
    rsv(4'd5);
    step();
    check("scale_busy_vec", 32'(busy_vec), 32'h1020);
    sel[0] = '{4'd1, 4'd15, 4'd7, 4'd0};
    sel[1] = '{4'd3, 4'd8, 4'd12, 4'd14};
    sel[2] = '{4'd5, 4'd5, 4'd2, 4'd11};
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < NRD; j++) rsel(j, sel[s][j]);
      #1;
      for (int j = 0; j < NRD; j++) begin
        check($sformatf("scale_s%0d_rd%0d", s, j), rd(j), 32'(int'(sel[s][j]) * 3));
        check($sformatf("scale_s%0d_busy%0d", s, j), 32'(rbusy[j]),
              (sel[s][j] == 4'd5 || sel[s][j] == 4'd12) ? 32'h1 : 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
